cache_controller_v2: RTL

//  Parametrised set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM controller.

---
 rtl/cache_controller_v2_pkg.sv | 16 +
 rtl/cache_controller_v2_lru.sv | 37 +++
 rtl/cache_controller_v2.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_v2_pkg.sv
// Shared types and helpers for the v2 data cache.
// Controller states plus a width helper safe for 1-entry dimensions.
package cache_controller_v2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } state_t;

  function automatic int wbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_controller_v2_lru.sv
// True-LRU helper for one set: age update on touch and victim pick.
// Age 0 is most recent; age WAYS-1 is the eviction candidate.
module cache_lru_set #(
  parameter int WAYS = 2,
  parameter int AW   = 1
) (
  input  logic [WAYS*AW-1:0] age_in,
  input  logic [WAYS-1:0]    valid_in,
  input  logic [AW-1:0]      way,
  output logic [WAYS*AW-1:0] age_out,
  output logic [AW-1:0]      victim
);

  logic [AW-1:0] cur;
  logic [AW-1:0] a;

  always_comb begin
    age_out = age_in;
    victim  = '0;
    a       = '0;
    cur     = age_in[way*AW +: AW];
    for (int w = 0; w < WAYS; w++) begin
      a = age_in[w*AW +: AW];
      if (AW'(w) == way)
        age_out[w*AW +: AW] = '0;
      else if (a < cur)
        age_out[w*AW +: AW] = a + 1'b1;
      if (a == AW'(WAYS - 1))
        victim = AW'(w);
    end
    // an invalid way always beats the oldest one; lowest index wins
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_in[w])
        victim = AW'(w);
  end

endmodule

// File: rtl/cache_controller_v2.sv
// Set-associative write-through, no-write-allocate data cache.
// Sits between the MEM stage and the SRAM controller; ~ready stalls.
module cache_controller_v2 #(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  parameter int WPL  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_read,
  output logic        sram_write,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  import cache_controller_v2_pkg::*;

  localparam int OB = $clog2(WPL);
  localparam int IB = $clog2(SETS);
  localparam int TW = 30 - OB - IB;
  localparam int AW = wbits(WAYS);
  localparam int CW = wbits(WPL);

  logic [29:0]   wa;
  logic [CW-1:0] off;
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;

  assign wa  = address[31:2];
  assign off = CW'(wa) & CW'(WPL - 1);
  assign idx = IB'(wa >> OB);
  assign tag = TW'(wa >> (OB + IB));

  logic unused;
  assign unused = ^address[1:0];

  state_t        state;
  logic [CW-1:0] cnt;
  logic [IB-1:0] fcnt;
  logic [IB-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [AW-1:0] fill_way;
  logic          flush_pend;
  logic          post_fill;

  logic [31:0]        data [SETS][WAYS][WPL];
  logic [TW-1:0]      tags [SETS][WAYS];
  logic [WAYS-1:0]    valid [SETS];
  logic [WAYS*AW-1:0] age [SETS];
  logic [31:0]        lbuf [WPL];

  logic          hit;
  logic [AW-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
  end

  logic [IB-1:0]      lru_idx;
  logic [AW-1:0]      lru_way;
  logic [AW-1:0]      victim;
  logic [WAYS*AW-1:0] age_nx;

  assign lru_idx = (state == FILL) ? fill_idx : idx;
  assign lru_way = (state == FILL) ? fill_way : hit_way;

  cache_lru_set #(
    .WAYS(WAYS),
    .AW  (AW)
  ) u_lru (
    .age_in  (age[lru_idx]),
    .valid_in(valid[lru_idx]),
    .way     (lru_way),
    .age_out (age_nx),
    .victim  (victim)
  );

  logic idle_ok;
  logic rd_req;
  logic fill_last;

  assign idle_ok   = state == IDLE && !flush_pend && !flush;
  assign rd_req    = MEM_R_EN && !MEM_W_EN;
  assign fill_last = sram_ready && cnt == CW'(WPL - 1);

  assign ready =
    (idle_ok && ((!MEM_R_EN && !MEM_W_EN) || (rd_req && hit))) ||
    (state == WRITE && sram_ready);

  assign rdata = (state == IDLE && hit) ? data[idx][hit_way][off] : '0;

  logic [29:0] fill_wa;
  assign fill_wa = (30'({fill_tag, fill_idx}) << OB) | 30'(cnt);

  assign sram_address = sram_read  ? {fill_wa, 2'b00} :
                        sram_write ? {wa, 2'b00} : '0;
  assign sram_wdata   = sram_write ? wdata : '0;

  function automatic logic [WAYS*AW-1:0] age_rst();
    age_rst = '0;
    for (int w = 0; w < WAYS; w++)
      age_rst[w*AW +: AW] = AW'(w);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fcnt       <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      fill_way   <= '0;
      flush_pend <= 1'b0;
      post_fill  <= 1'b0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        age[s]   <= age_rst();
      end
    end else begin
      if (state == IDLE && ready)
        post_fill <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            state <= FLUSH;
            fcnt  <= '0;
          end else if (MEM_W_EN) begin
            state      <= WRITE;
            sram_write <= 1'b1;
          end else if (MEM_R_EN && hit) begin
            age[idx] <= age_nx;
            // the completing hit after a fill was already a miss
            if (!post_fill)
              hit_count <= hit_count + 32'd1;
          end else if (MEM_R_EN) begin
            miss_count <= miss_count + 32'd1;
            fill_tag   <= tag;
            fill_idx   <= idx;
            fill_way   <= victim;
            cnt        <= '0;
            state      <= FILL;
            sram_read  <= 1'b1;
          end
        end
        FILL: begin
          if (sram_ready) begin
            cnt <= cnt + 1'b1;
            if (fill_last) begin
              valid[fill_idx][fill_way] <= 1'b1;
              age[fill_idx] <= age_nx;
              post_fill     <= 1'b1;
              state         <= IDLE;
              sram_read     <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state      <= IDLE;
            sram_write <= 1'b0;
          end
        end
        FLUSH: begin
          valid[fcnt] <= '0;
          fcnt        <= fcnt + 1'b1;
          if (fcnt == IB'(SETS - 1)) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush)
        flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && sram_ready) begin
      lbuf[cnt] <= sram_rdata;
      if (fill_last) begin
        tags[fill_idx][fill_way] <= fill_tag;
        for (int k = 0; k < WPL; k++)
          data[fill_idx][fill_way][k] <=
            (k == WPL - 1) ? sram_rdata : lbuf[k];
      end
    end
    if (idle_ok && MEM_W_EN && hit)
      data[idx][hit_way][off] <= wdata;
  end

endmodule
